// File: rtl/syscall_sequencer.sv
// Syscall sequencer: reads $v0/$a0 over regfile port A, then halts, displays-and-pauses or waits for resume.
// Latency: stall asserts at trigger and drops in RELEASE (T+4+P for display); PC is held by stall, no other backpressure.
module syscall_sequencer #(
    parameter int CNT_W = 16,
    parameter int SC_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             syscall_en,
    input  logic             resume,
    input  logic [CNT_W-1:0] pause_cycles,
    input  logic [31:0]      rf_data_a,
    output logic             rf_sel,
    output logic [4:0]       rf_req_a,
    output logic             stall,
    output logic             halted,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic             err_unknown,
    output logic [SC_W-1:0]  sys_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_V0, S_RD_A0, S_EXEC, S_PAUSE, S_WAIT, S_HALT, S_RELEASE
    } state_t;

    state_t           state_q;
    logic [31:0]      v0_q;
    logic [31:0]      a0_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rf_sel_q;
    logic [4:0]       rf_req_q;
    logic             busy_q;
    logic             halted_q;
    logic [31:0]      disp_data_q;
    logic             disp_valid_q;
    logic             err_q;
    logic [SC_W-1:0]  sys_cnt_q;

    // Outputs are registered against the destination state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            v0_q         <= '0;
            a0_q         <= '0;
            cnt_q        <= '0;
            rf_sel_q     <= 1'b0;
            rf_req_q     <= '0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            sys_cnt_q    <= '0;
        end else begin
            disp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (syscall_en) begin
                        state_q  <= S_RD_V0;
                        rf_sel_q <= 1'b1;
                        rf_req_q <= 5'd2;
                        busy_q   <= 1'b1;
                    end
                end
                S_RD_V0: begin
                    v0_q     <= rf_data_a;
                    rf_req_q <= 5'd4;
                    state_q  <= S_RD_A0;
                end
                S_RD_A0: begin
                    a0_q     <= rf_data_a;
                    rf_sel_q <= 1'b0;
                    rf_req_q <= '0;
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    if (v0_q == 32'd10) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (v0_q == 32'd1 || v0_q == 32'd34) begin
                        disp_data_q  <= a0_q;
                        disp_valid_q <= 1'b1;
                        cnt_q        <= pause_cycles;
                        if (pause_cycles != '0) begin
                            state_q <= S_PAUSE;
                        end else begin
                            state_q <= S_RELEASE;
                            busy_q  <= 1'b0;
                        end
                    end else if (v0_q == 32'd50) begin
                        state_q <= S_WAIT;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_RELEASE;
                        busy_q  <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RELEASE;
                        busy_q  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (resume) begin
                        state_q <= S_RELEASE;
                        busy_q  <= 1'b0;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                S_RELEASE: begin
                    // The retiring syscall is still on syscall_en here, so it must not retrigger.
                    sys_cnt_q <= sys_cnt_q + SC_W'(1);
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stall       = busy_q | ((state_q == S_IDLE) & syscall_en);
    assign rf_sel      = rf_sel_q;
    assign rf_req_a    = rf_req_q;
    assign halted      = halted_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign err_unknown = err_q;
    assign sys_count   = sys_cnt_q;

endmodule
